tape_io_dev: RTL and testbench
==============================

TAPE_IO_DEV -- requirements
Module: tape_io_dev

Interface
REQ-001 SHALL have parameter DEPTH, default 8; reader and punch FIFO depth in 5-bit characters (power of 2, 2..64).
REQ-002 SHALL have parameter CHAR_GAP, default 4; minimum idle cycles between characters, emulating tape speed (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dev_input_rdy  input  1  core requests one input character (level).
REQ-006 SHALL have port dev_input_val  output  1  character valid (one-cycle pulse).
REQ-007 SHALL have port dev_input_data  output  5  character, stable from the pulse until the next pulse.
REQ-008 SHALL have port dev_output_rdy  input  1  core presents one output character (level).
REQ-009 SHALL have port dev_output_data  input  5  output character, valid while dev_output_rdy=1.
REQ-010 SHALL have port dev_output_ack  output  1  character captured (one-cycle pulse).
REQ-011 SHALL have ports reader_en and punch_en  input  1 each  enable reader and punch transfers (level).
REQ-012 SHALL have ports host_wr_en (input, 1), host_wr_data (input, 5), reader_full (output, 1), reader_empty (output, 1); host loads the reader FIFO.
REQ-013 SHALL have ports host_rd_en (input, 1), host_rd_data (output, 5), punch_full (output, 1), punch_empty (output, 1); host drains the punch FIFO.

Function
REQ-014 Reader FSM SHALL have states R_IDLE, R_SEND, R_WAIT_LOW, R_GAP.
REQ-015 R_IDLE->R_SEND SHALL occur when dev_input_rdy=1, reader_en=1 and reader FIFO not empty; else stay in R_IDLE.
REQ-016 In R_SEND (exactly one cycle) SHALL drive dev_input_val=1, present the FIFO head on dev_input_data, pop the FIFO, then go to R_WAIT_LOW; val rises one cycle after the qualifying R_IDLE cycle.
REQ-017 R_WAIT_LOW SHALL hold until dev_input_rdy=0 is sampled, then enter R_GAP; rdy held high never produces a second pulse.
REQ-018 R_GAP SHALL last exactly CHAR_GAP cycles, then return to R_IDLE.
REQ-019 Punch FSM SHALL have states P_IDLE, P_ACK, P_WAIT_LOW, P_GAP, with P_IDLE->P_ACK when dev_output_rdy=1, punch_en=1 and punch FIFO not full.
REQ-020 In P_ACK (exactly one cycle) SHALL drive dev_output_ack=1 and push dev_output_data sampled in that cycle, then follow the same WAIT_LOW/GAP rules as the reader.
REQ-021 Punch FIFO full SHALL hold P_IDLE (no ack) until space exists: backpressure, no character lost.
REQ-022 Deasserting reader_en/punch_en SHALL only block the IDLE->SEND/ACK transition; a transfer in progress completes.
REQ-023 Host write to a full reader FIFO SHALL be ignored unless a pop occurs in the same cycle, in which case both take effect.
REQ-024 Host read of an empty punch FIFO SHALL be ignored; simultaneous push and pop SHALL both take effect, leaving count unchanged.
REQ-025 host_rd_data SHALL show the punch FIFO head combinationally (show-ahead); host_rd_en pops it; value is don't-care when empty.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; full/empty flags SHALL be exact at count DEPTH and 0 and registered.
REQ-027 Reader and punch SHALL operate independently and concurrently.

Reset
REQ-028 resetn=0 SHALL immediately force both FSMs to IDLE, both FIFOs empty, and the gap counters to 0.
REQ-029 While in reset, dev_input_val=0, dev_output_ack=0, dev_input_data=0, reader_empty=1, punch_empty=1, reader_full=0, punch_full=0.
REQ-030 Reset during R_SEND/P_ACK SHALL truncate the pulse asynchronously; the character is lost and no recovery is attempted.

Verification
REQ-031 Load 5'h01,5'h1F,5'h0A; hold rdy=1, drop rdy one cycle after each val -> three val pulses, data 01,1F,0A, successive val rising edges >= CHAR_GAP+2 cycles apart.
REQ-032 Hold dev_input_rdy=1 continuously with two characters loaded -> exactly one val pulse (data = first char); second pulse only after rdy drops.
REQ-033 DEPTH=8: write 9 characters with no pop -> reader_full=1 after the 8th, 9th ignored; drain -> exactly 8 delivered, reader_empty=1.
REQ-034 Core presents 5'h15 with punch FIFO full -> no ack; host_rd_en one cycle -> ack next-but-one cycle, 5'h15 appears at the tail.
REQ-035 Assert resetn=0 during R_SEND -> val drops in the same cycle; after release all flags at reset values and no spurious pulse.
REQ-036 Concurrent reader and punch streams of 16 characters each with random rdy/host timing -> punch output equals core output sequence, no loss, no duplicates.

Source files
------------

// File: rtl/tape_io_dev.sv
// Paper-tape style I/O device. It has two independent channels.
//   Reader: the host loads 5-bit characters into a FIFO, and the core pulls
//           them one at a time with a rdy/val handshake.
//   Punch:  the core pushes 5-bit characters with a rdy/ack handshake, and the
//           host drains them from a show-ahead FIFO.
// Each handshake waits for the core's rdy to go low. It then idles for
// CHAR_GAP cycles before the next character, which emulates tape speed.
// Ports:
//   clk, resetn                        clock, async active-low reset
//   dev_input_rdy/val/data             core <- reader handshake
//   dev_output_rdy/data/ack            core -> punch handshake
//   reader_en, punch_en                per-channel transfer enables
//   host_wr_en/data, reader_full/empty host side of the reader FIFO
//   host_rd_en/data, punch_full/empty  host side of the punch FIFO
module tape_io_dev #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CHAR_GAP = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       dev_input_rdy,
  output logic       dev_input_val,
  output logic [4:0] dev_input_data,
  input  logic       dev_output_rdy,
  input  logic [4:0] dev_output_data,
  output logic       dev_output_ack,
  input  logic       reader_en,
  input  logic       punch_en,
  input  logic       host_wr_en,
  input  logic [4:0] host_wr_data,
  output logic       reader_full,
  output logic       reader_empty,
  input  logic       host_rd_en,
  output logic [4:0] host_rd_data,
  output logic       punch_full,
  output logic       punch_empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NW = PW + 1;
  localparam int unsigned GW = 8;

  typedef enum logic [1:0] {R_IDLE, R_SEND, R_WAIT_LOW, R_GAP} r_state_t;
  typedef enum logic [1:0] {P_IDLE, P_ACK, P_WAIT_LOW, P_GAP} p_state_t;

  r_state_t r_state;
  p_state_t p_state;
  logic [GW-1:0] r_gap, p_gap;

  // ---------------- reader FIFO ----------------
  logic [4:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [NW-1:0] r_cnt, r_cnt_nxt;
  logic          r_push, r_pop;

  // A write to a full FIFO still lands when the reader pops in the same cycle.
  assign r_pop  = (r_state == R_SEND) && !reader_empty;
  assign r_push = host_wr_en && (!reader_full || r_pop);

  always_comb begin
    r_cnt_nxt = r_cnt;
    if (r_push && !r_pop)      r_cnt_nxt = r_cnt + NW'(1);
    else if (!r_push && r_pop) r_cnt_nxt = r_cnt - NW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      reader_full  <= 1'b0;
      reader_empty <= 1'b1;
    end else begin
      if (r_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (r_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_cnt        <= r_cnt_nxt;
      reader_full  <= (r_cnt_nxt == NW'(DEPTH));
      reader_empty <= (r_cnt_nxt == '0);
    end
  end

  // Storage needs no reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (r_push) r_mem[r_wr_ptr] <= host_wr_data;
  end

  // ---------------- punch FIFO ----------------
  logic [4:0]    p_mem [DEPTH];
  logic [PW-1:0] p_wr_ptr, p_rd_ptr;
  logic [NW-1:0] p_cnt, p_cnt_nxt;
  logic          p_push, p_pop;

  assign p_pop  = host_rd_en && !punch_empty;
  assign p_push = (p_state == P_ACK) && (!punch_full || p_pop);

  always_comb begin
    p_cnt_nxt = p_cnt;
    if (p_push && !p_pop)      p_cnt_nxt = p_cnt + NW'(1);
    else if (!p_push && p_pop) p_cnt_nxt = p_cnt - NW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_wr_ptr    <= '0;
      p_rd_ptr    <= '0;
      p_cnt       <= '0;
      punch_full  <= 1'b0;
      punch_empty <= 1'b1;
    end else begin
      if (p_push) p_wr_ptr <= p_wr_ptr + PW'(1);
      if (p_pop)  p_rd_ptr <= p_rd_ptr + PW'(1);
      p_cnt       <= p_cnt_nxt;
      punch_full  <= (p_cnt_nxt == NW'(DEPTH));
      punch_empty <= (p_cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (p_push) p_mem[p_wr_ptr] <= dev_output_data;
  end

  // Show-ahead head of the punch FIFO.
  assign host_rd_data = p_mem[p_rd_ptr];

  // ---------------- reader FSM ----------------
  // val and data are loaded on entry to R_SEND, so the pulse is exactly that state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= R_IDLE;
      r_gap          <= '0;
      dev_input_val  <= 1'b0;
      dev_input_data <= '0;
    end else begin
      dev_input_val <= 1'b0;
      case (r_state)
        R_IDLE: if (dev_input_rdy && reader_en && !reader_empty) begin
          r_state        <= R_SEND;
          dev_input_val  <= 1'b1;
          dev_input_data <= r_mem[r_rd_ptr];
        end
        R_SEND: r_state <= R_WAIT_LOW;
        R_WAIT_LOW: if (!dev_input_rdy) begin
          r_state <= R_GAP;
          r_gap   <= GW'(CHAR_GAP - 1);
        end
        R_GAP: begin
          if (r_gap == '0) r_state <= R_IDLE;
          else             r_gap   <= r_gap - GW'(1);
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- punch FSM ----------------
  // A full FIFO holds off the ack, so the core keeps presenting its character.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_state        <= P_IDLE;
      p_gap          <= '0;
      dev_output_ack <= 1'b0;
    end else begin
      dev_output_ack <= 1'b0;
      case (p_state)
        P_IDLE: if (dev_output_rdy && punch_en && !punch_full) begin
          p_state        <= P_ACK;
          dev_output_ack <= 1'b1;
        end
        P_ACK: p_state <= P_WAIT_LOW;
        P_WAIT_LOW: if (!dev_output_rdy) begin
          p_state <= P_GAP;
          p_gap   <= GW'(CHAR_GAP - 1);
        end
        P_GAP: begin
          if (p_gap == '0) p_state <= P_IDLE;
          else             p_gap   <= p_gap - GW'(1);
        end
        default: p_state <= P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tape_io_dev.sv
// Self-checking bench for tape_io_dev. Queues model both FIFOs: the reader
// must deliver exactly what the host accepted, and the punch must hand the
// host exactly what the core presented, in order. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_tape_io_dev;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned CHAR_GAP = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       dev_input_rdy, dev_input_val;
  logic [4:0] dev_input_data;
  logic       dev_output_rdy, dev_output_ack;
  logic [4:0] dev_output_data;
  logic       reader_en, punch_en;
  logic       host_wr_en, host_rd_en;
  logic [4:0] host_wr_data, host_rd_data;
  logic       reader_full, reader_empty, punch_full, punch_empty;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [4:0] rq[$];   // characters accepted into the reader, not yet delivered
  logic [4:0] pq[$];   // characters acked by the punch, not yet drained

  tape_io_dev #(.DEPTH(DEPTH), .CHAR_GAP(CHAR_GAP)) dut (
    .clk(clk), .resetn(resetn),
    .dev_input_rdy(dev_input_rdy), .dev_input_val(dev_input_val), .dev_input_data(dev_input_data),
    .dev_output_rdy(dev_output_rdy), .dev_output_data(dev_output_data), .dev_output_ack(dev_output_ack),
    .reader_en(reader_en), .punch_en(punch_en),
    .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
    .reader_full(reader_full), .reader_empty(reader_empty),
    .host_rd_en(host_rd_en), .host_rd_data(host_rd_data),
    .punch_full(punch_full), .punch_empty(punch_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // The caller is at a falling edge. The model accepts only when not full.
  task automatic host_write(input logic [4:0] d);
    host_wr_en   = 1'b1;
    host_wr_data = d;
    if (rq.size() < DEPTH) rq.push_back(d);
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  // Request one character. Drop rdy when val is seen, and hold it low long
  // enough for the reader to leave its wait-low state.
  task automatic reader_fetch(input int budget, input bit expect_char, output int t);
    bit got = 1'b0;
    logic [4:0] d = '0;
    logic [4:0] exp_d;
    t = 0;
    dev_input_rdy = 1'b1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (dev_input_val === 1'b1) begin got = 1'b1; d = dev_input_data; t = cyc; end
    end
    dev_input_rdy = 1'b0;
    checks++;
    if (got !== expect_char) begin
      errors++; $display("FAIL reader_val_seen got=%b exp=%b", got, expect_char);
    end
    if (got) begin
      checks++;
      if (rq.size() == 0) begin
        errors++; $display("FAIL reader_data got=%h exp=<none>", d);
      end else begin
        exp_d = rq.pop_front();
        if (d !== exp_d) begin errors++; $display("FAIL reader_data got=%h exp=%h", d, exp_d); end
      end
    end
    @(negedge clk);
    if (got) begin
      checks++;
      if (dev_input_val !== 1'b0 || dev_input_data !== d) begin
        errors++; $display("FAIL reader_pulse val=%b data=%h exp val=0 data=%h", dev_input_val, dev_input_data, d);
      end
    end
    @(negedge clk);
  endtask

  // Present one character to the punch. The model records it at the ack.
  task automatic core_send(input logic [4:0] d, input int budget);
    bit got = 1'b0;
    dev_output_data = d;
    dev_output_rdy  = 1'b1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (dev_output_ack === 1'b1) begin got = 1'b1; pq.push_back(d); end
    end
    dev_output_rdy = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL punch_ack_timeout got=0 exp=1 data=%h", d); end
    @(negedge clk);
    if (got) begin
      checks++;
      if (dev_output_ack !== 1'b0) begin errors++; $display("FAIL punch_ack_width ack=%b exp=0", dev_output_ack); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [10:0] v;
    resetn = 1'b0;
    dev_input_rdy = 0; dev_output_rdy = 0; dev_output_data = 0;
    reader_en = 0; punch_en = 0; host_wr_en = 0; host_wr_data = 0; host_rd_en = 0;
    rq.delete(); pq.delete();
    @(negedge clk);
    v = {dev_input_val, dev_output_ack, dev_input_data, reader_empty, punch_empty, reader_full, punch_full};
    checks++;
    if (v !== 11'b00_00000_1100) begin errors++; $display("FAIL reset_in_reset got=%b exp=%b", v, 11'b00_00000_1100); end
    resetn = 1'b1;
    @(negedge clk);
    v = {dev_input_val, dev_output_ack, dev_input_data, reader_empty, punch_empty, reader_full, punch_full};
    checks++;
    if (v !== 11'b00_00000_1100) begin errors++; $display("FAIL reset_released got=%b exp=%b", v, 11'b00_00000_1100); end
  endtask

  task automatic test_reader_basic();
    int t, t_prev;
    reader_en = 1'b1;
    @(negedge clk);
    host_write(5'h01); host_write(5'h1F); host_write(5'h0A);
    for (int i = 0; i < 3; i++) begin
      reader_fetch(60, 1'b1, t);
      if (i > 0) begin
        checks++;
        if (t - t_prev < int'(CHAR_GAP) + 2) begin
          errors++; $display("FAIL reader_spacing got=%0d exp>=%0d", t - t_prev, CHAR_GAP + 2);
        end
      end
      t_prev = t;
    end
    checks++;
    if (reader_empty !== 1'b1) begin errors++; $display("FAIL reader_empty_after got=%b exp=1", reader_empty); end
  endtask

  task automatic test_rdy_held();
    int pulses = 0;
    int t;
    logic [4:0] a, b, first_d;
    a = 5'($urandom); b = 5'($urandom);
    first_d = '0;
    host_write(a); host_write(b);
    dev_input_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dev_input_val === 1'b1) begin pulses++; if (pulses == 1) first_d = dev_input_data; end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL rdy_held_pulses got=%0d exp=1", pulses); end
    checks++;
    if (first_d !== a) begin errors++; $display("FAIL rdy_held_data got=%h exp=%h", first_d, a); end
    void'(rq.pop_front());
    dev_input_rdy = 1'b0;
    @(negedge clk); @(negedge clk);
    reader_fetch(60, 1'b1, t);
  endtask

  task automatic test_reader_full();
    int t;
    reader_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      host_write(5'($urandom));
      checks++;
      if (reader_full !== (i >= 7)) begin errors++; $display("FAIL reader_full_w%0d got=%b exp=%b", i, reader_full, i >= 7); end
    end
    reader_en = 1'b1;
    for (int i = 0; i < 8; i++) reader_fetch(60, 1'b1, t);
    reader_fetch(30, 1'b0, t);
    checks++;
    if (reader_empty !== 1'b1) begin errors++; $display("FAIL reader_drained_empty got=%b exp=1", reader_empty); end
  endtask

  task automatic test_punch_backpressure();
    bit saw = 1'b0;
    logic [4:0] e;
    punch_en = 1'b1;
    for (int i = 0; i < 8; i++) core_send(5'($urandom), 40);
    checks++;
    if (punch_full !== 1'b1) begin errors++; $display("FAIL punch_full got=%b exp=1", punch_full); end
    dev_output_data = 5'h15;
    dev_output_rdy  = 1'b1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (dev_output_ack === 1'b1) saw = 1'b1; end
    checks++;
    if (saw) begin errors++; $display("FAIL punch_ack_while_full got=1 exp=0"); end
    e = pq.pop_front();
    checks++;
    if (host_rd_data !== e) begin errors++; $display("FAIL punch_head got=%h exp=%h", host_rd_data, e); end
    host_rd_en = 1'b1;
    @(negedge clk);
    host_rd_en = 1'b0;
    checks++;
    if (dev_output_ack !== 1'b0) begin errors++; $display("FAIL punch_ack_early got=%b exp=0", dev_output_ack); end
    @(negedge clk);
    checks++;
    if (dev_output_ack !== 1'b1) begin errors++; $display("FAIL punch_ack_after_pop got=%b exp=1", dev_output_ack); end
    else pq.push_back(5'h15);
    dev_output_rdy = 1'b0;
    @(negedge clk); @(negedge clk);
    while (pq.size() > 0) begin
      e = pq.pop_front();
      checks++;
      if (host_rd_data !== e) begin errors++; $display("FAIL punch_drain got=%h exp=%h", host_rd_data, e); end
      host_rd_en = 1'b1;
      @(negedge clk);
    end
    host_rd_en = 1'b1;     // one extra read while empty must be ignored
    @(negedge clk);
    host_rd_en = 1'b0;
    checks++;
    if (punch_empty !== 1'b1) begin errors++; $display("FAIL punch_empty_after got=%b exp=1", punch_empty); end
    core_send(5'h0B, 40);
    e = pq.pop_front();
    checks++;
    if (host_rd_data !== e || punch_empty !== 1'b0) begin
      errors++; $display("FAIL punch_after_empty_read data=%h empty=%b exp data=%h empty=0", host_rd_data, punch_empty, e);
    end
    host_rd_en = 1'b1;
    @(negedge clk);
    host_rd_en = 1'b0;
  endtask

  task automatic test_concurrent();
    int drained = 0;
    reader_en = 1'b1; punch_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          int g = 0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          while (reader_full && g < 400) begin @(negedge clk); g++; end
          host_write(5'($urandom));
        end
      end
      begin
        int t;
        for (int i = 0; i < 16; i++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          reader_fetch(400, 1'b1, t);
        end
      end
      begin
        for (int i = 0; i < 16; i++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          core_send(5'($urandom), 400);
        end
      end
      begin
        logic [4:0] e;
        for (int c = 0; c < 6000 && drained < 16; c++) begin
          @(negedge clk);
          host_rd_en = 1'b0;
          if (!punch_empty && $urandom_range(0, 1) == 1) begin
            checks++;
            if (pq.size() == 0) begin
              errors++; $display("FAIL conc_punch_extra got=%h exp=<none>", host_rd_data);
            end else begin
              e = pq.pop_front();
              if (host_rd_data !== e) begin errors++; $display("FAIL conc_punch_data got=%h exp=%h", host_rd_data, e); end
            end
            host_rd_en = 1'b1;
            drained++;
          end
        end
        @(negedge clk);
        host_rd_en = 1'b0;
      end
    join
    checks++;
    if (drained !== 16 || punch_empty !== 1'b1 || reader_empty !== 1'b1) begin
      errors++; $display("FAIL conc_totals drained=%0d punch_empty=%b reader_empty=%b exp 16 1 1", drained, punch_empty, reader_empty);
    end
  endtask

  task automatic test_reset_during_send();
    logic [10:0] v;
    bit seen = 1'b0;
    int pulses = 0;
    reader_en = 1'b1;
    host_write(5'($urandom)); host_write(5'($urandom));
    dev_input_rdy = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dev_input_val === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_send_no_val got=0 exp=1"); end
    resetn = 1'b0;
    rq.delete(); pq.delete();
    #1;
    v = {dev_input_val, dev_output_ack, dev_input_data, reader_empty, punch_empty, reader_full, punch_full};
    checks++;
    if (v !== 11'b00_00000_1100) begin errors++; $display("FAIL rst_send_async got=%b exp=%b", v, 11'b00_00000_1100); end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dev_input_val === 1'b1) pulses++;
    end
    v = {dev_input_val, dev_output_ack, dev_input_data, reader_empty, punch_empty, reader_full, punch_full};
    checks++;
    if (pulses !== 0 || v !== 11'b00_00000_1100) begin
      errors++; $display("FAIL rst_send_after pulses=%0d flags=%b exp 0 %b", pulses, v, 11'b00_00000_1100);
    end
    dev_input_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reader_basic();
    test_rdy_held();
    test_reader_full();
    test_punch_backpressure();
    test_concurrent();
    test_reset_during_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
